// File: rtl/matrix_walk_ctrl.sv
// matrix_walk_ctrl
//   Walks an rows x cols matrix stored column-major. It issues one read request
//   per element and counts outstanding reads against a fixed limit. It finishes
//   with a one-cycle done pulse once every response has returned.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : launch pulse, honoured only while idle
//   cfg_rows/cfg_cols/cfg_base: walk geometry and base byte address (latched on start)
//   busy, done                : walk in progress / one-cycle completion pulse
//   req_valid/req_ready       : read request handshake
//   req_addr/req_row/req_col  : request payload, held stable until accepted
//   req_last                  : payload is the final element of the walk
//   rsp_valid                 : one read response returned this cycle
//   err_unexp                 : sticky flag, a response arrived with nothing outstanding
module matrix_walk_ctrl #(
    parameter int ROW_WIDTH  = 5,
    parameter int COL_WIDTH  = 5,
    parameter int ADDR_WIDTH = 64,
    parameter int ELEM_BYTES = 4,
    parameter int MAX_OST    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  cfg_rows,
    input  logic [COL_WIDTH-1:0]  cfg_cols,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    output logic                  busy,
    output logic                  done,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ROW_WIDTH-1:0]  req_row,
    output logic [COL_WIDTH-1:0]  req_col,
    output logic                  req_last,
    input  logic                  rsp_valid,
    output logic                  err_unexp
);

    localparam int OST_WIDTH = $clog2(MAX_OST + 1);
    localparam logic [OST_WIDTH-1:0]  OST_LIMIT = OST_WIDTH'(MAX_OST);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ELEM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ROW_WIDTH-1:0]  rows_reg, rows_next;
    logic [COL_WIDTH-1:0]  cols_reg, cols_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [ROW_WIDTH-1:0]  row_reg, row_next;
    logic [COL_WIDTH-1:0]  col_reg, col_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [OST_WIDTH-1:0]  ost_reg, ost_next;
    logic                  err_reg, err_next;

    logic row_at_end;
    logic col_at_end;
    logic accept;
    logic rsp_take;

    assign row_at_end = (row_reg == rows_reg - ROW_WIDTH'(1));
    assign col_at_end = (col_reg == cols_reg - COL_WIDTH'(1));

    // req_valid depends only on registered state, so the payload registers
    // (which only move on accept) stay stable under backpressure.
    assign req_valid = (state_reg == RUN) && (ost_reg < OST_LIMIT);
    assign req_last  = (state_reg == RUN) && row_at_end && col_at_end;
    assign accept    = req_valid && req_ready;
    // A response only retires a read if one is actually outstanding; a stray
    // response is flagged and otherwise discarded.
    assign rsp_take  = rsp_valid && (ost_reg != '0);

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign req_addr  = addr_reg;
    assign req_row   = row_reg;
    assign req_col   = col_reg;
    assign err_unexp = err_reg;

    always_comb begin
        state_next = state_reg;
        rows_next  = rows_reg;
        cols_next  = cols_reg;
        base_next  = base_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        addr_next  = addr_reg;
        ost_next   = ost_reg;
        err_next   = err_reg;

        if (rsp_valid && (ost_reg == '0)) begin
            err_next = 1'b1;
        end

        // Accept and retire in the same cycle cancel out.
        unique case ({accept, rsp_take})
            2'b10:   ost_next = ost_reg + OST_WIDTH'(1);
            2'b01:   ost_next = ost_reg - OST_WIDTH'(1);
            default: ost_next = ost_reg;
        endcase

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    rows_next  = cfg_rows;
                    cols_next  = cfg_cols;
                    base_next  = cfg_base;
                    row_next   = '0;
                    col_next   = '0;
                    addr_next  = cfg_base;
                    ost_next   = '0;
                    state_next = ((cfg_rows == '0) || (cfg_cols == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    // Running address sum replaces base + (col*rows+row)*ELEM_BYTES.
                    addr_next = addr_reg + ADDR_STEP;
                    if (row_at_end) begin
                        row_next = '0;
                        col_next = col_reg + COL_WIDTH'(1);
                    end else begin
                        row_next = row_reg + ROW_WIDTH'(1);
                    end
                    if (row_at_end && col_at_end) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Looks at the updated count so a final response lands us in DONE next cycle.
                if (ost_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rows_reg  <= '0;
            cols_reg  <= '0;
            base_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            addr_reg  <= '0;
            ost_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rows_reg  <= rows_next;
            cols_reg  <= cols_next;
            base_reg  <= base_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            addr_reg  <= addr_next;
            ost_reg   <= ost_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_matrix_walk_ctrl.sv
// Testbench for matrix_walk_ctrl: table-driven basic walk, hand sequences for
// corner cases, and randomized walks checked against a transaction-level model.
module tb_matrix_walk_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 5;
    localparam int AW   = 64;
    localparam int EB   = 4;
    localparam int MOST = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, req_ready, rsp_valid;
    logic [RW-1:0] cfg_rows;
    logic [CW-1:0] cfg_cols;
    logic [AW-1:0] cfg_base;
    logic          busy, done, req_valid, req_last, err_unexp;
    logic [AW-1:0] req_addr;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;

    logic          start8, req_ready8, rsp_valid8;
    logic [RW-1:0] cfg_rows8;
    logic [CW-1:0] cfg_cols8;
    logic [7:0]    cfg_base8;
    logic          busy8, done8, req_valid8, req_last8, err_unexp8;
    logic [7:0]    req_addr8;
    logic [RW-1:0] req_row8;
    logic [CW-1:0] req_col8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matrix_walk_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
        .busy(busy), .done(done),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_row(req_row), .req_col(req_col), .req_last(req_last),
        .rsp_valid(rsp_valid), .err_unexp(err_unexp)
    );

    matrix_walk_ctrl #(.ADDR_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .cfg_rows(cfg_rows8), .cfg_cols(cfg_cols8), .cfg_base(cfg_base8),
        .busy(busy8), .done(done8),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_addr(req_addr8),
        .req_row(req_row8), .req_col(req_col8), .req_last(req_last8),
        .rsp_valid(rsp_valid8), .err_unexp(err_unexp8)
    );

    typedef struct {
        logic          st;
        logic          rdy;
        logic          rsp;
        logic          e_busy;
        logic          e_done;
        logic          e_valid;
        logic          e_last;
        logic [RW-1:0] e_row;
        logic [CW-1:0] e_col;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rdy, input logic rsp,
                                input logic b, input logic d, input logic v, input logic l,
                                input logic [RW-1:0] r, input logic [CW-1:0] c,
                                input logic [AW-1:0] a);
        vec_t x;
        x.st = st; x.rdy = rdy; x.rsp = rsp;
        x.e_busy = b; x.e_done = d; x.e_valid = v; x.e_last = l;
        x.e_row = r; x.e_col = c; x.e_addr = a;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: the walk is a list of total = rows*cols elements
    // in column-major order. Element k sits at row k%rows, col k/rows and byte
    // address base + (col*rows+row)*EB. Requests may be offered while fewer than
    // MOST reads are in flight. Once every element is issued and every read has
    // returned, done follows on the next cycle.
    task automatic run_walk(input int rows, input int cols, input logic [63:0] base, input int mode);
        int          total, issued, ost, stall, r, c;
        bit          walking, done_due, finished;
        logic        exp_valid;
        logic [63:0] a;
        total    = rows * cols;
        cfg_rows = RW'(rows);
        cfg_cols = CW'(cols);
        cfg_base = base;
        start = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
        tick();
        start    = 1'b0;
        walking  = 1'b1;
        issued   = 0;
        ost      = 0;
        stall    = 0;
        done_due = (total == 0);
        finished = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            exp_valid = walking && (issued < total) && (ost < MOST);
            case (mode)
                1:       req_ready = !(issued == 1 && stall < 5);
                2, 3:    req_ready = ($urandom_range(0, 3) != 0);
                default: req_ready = 1'b1;
            endcase
            if (!req_ready && exp_valid) stall++;
            rsp_valid = (ost > 0) && ($urandom_range(0, 1) == 1);
            if (mode == 3 || (mode == 2 && $urandom_range(0, 7) == 0)) begin
                start    = 1'b1;
                cfg_rows = RW'($urandom);
                cfg_cols = CW'($urandom);
                cfg_base = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            chk("walk_busy", busy, walking);
            chk("walk_done", done, done_due);
            chk("walk_req_valid", req_valid, exp_valid);
            if (exp_valid) begin
                r = issued % rows;
                c = issued / rows;
                a = base + 64'((c * rows + r) * EB);
                chk("walk_row", req_row, r);
                chk("walk_col", req_col, c);
                chk("walk_addr", req_addr, a);
                chk("walk_last", req_last, (issued == total - 1));
            end
            tick();
            if (exp_valid && req_ready) begin
                $display("req %0d/%0d row=%0d col=%0d addr=0x%0h last=%0b",
                         issued + 1, total, req_row, req_col, req_addr, req_last);
                issued++;
                ost++;
            end
            if (rsp_valid) ost--;
            if (done_due) begin
                finished = 1'b1;
                walking  = 1'b0;
            end else if (issued == total && ost == 0) begin
                done_due = 1'b1;
            end
        end
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        chk("walk_finished", finished, 1'b1);
        chk("walk_idle_after", busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[11];
        int   acc;
        bit   saw_done;

        rst = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        cfg_rows = '0; cfg_cols = '0; cfg_base = '0;
        start8 = 1'b0; req_ready8 = 1'b0; rsp_valid8 = 1'b0;
        cfg_rows8 = '0; cfg_cols8 = '0; cfg_base8 = '0;

        // Basic walk 3x2 at 0x1000, ready always high, each response 2 cycles after its accept.
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        vecs[1]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 64'h1000);
        vecs[2]  = mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 64'h1004);
        vecs[3]  = mk(0, 1, 1, 1, 0, 1, 0, 2, 0, 64'h1008);
        vecs[4]  = mk(0, 1, 1, 1, 0, 1, 0, 0, 1, 64'h100C);
        vecs[5]  = mk(0, 1, 1, 1, 0, 1, 0, 1, 1, 64'h1010);
        vecs[6]  = mk(0, 1, 1, 1, 0, 1, 1, 2, 1, 64'h1014);
        vecs[7]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 64'h0);
        vecs[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 64'h0);
        vecs[9]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 64'h0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_last", req_last, 1'b0);
        chk("rst_req_addr", req_addr, 64'h0);
        chk("rst_req_row", req_row, 0);
        chk("rst_req_col", req_col, 0);
        chk("rst_err_unexp", err_unexp, 1'b0);
        rst = 1'b0;
        tick();

        cfg_rows = 5'd3; cfg_cols = 5'd2; cfg_base = 64'h1000;
        for (int i = 0; i < 11; i++) begin
            start = vecs[i].st; req_ready = vecs[i].rdy; rsp_valid = vecs[i].rsp;
            chk($sformatf("tbl%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("tbl%0d_req_valid", i), req_valid, vecs[i].e_valid);
            chk($sformatf("tbl%0d_req_last", i), req_last, vecs[i].e_last);
            if (vecs[i].e_valid) begin
                chk($sformatf("tbl%0d_req_row", i), req_row, vecs[i].e_row);
                chk($sformatf("tbl%0d_req_col", i), req_col, vecs[i].e_col);
                chk($sformatf("tbl%0d_req_addr", i), req_addr, vecs[i].e_addr);
                if (vecs[i].rdy)
                    $display("tbl %0d row=%0d col=%0d addr=0x%0h last=%0b",
                             i, req_row, req_col, req_addr, req_last);
            end
            tick();
        end
        start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;

        // Backpressure: 5 stalled cycles on the 2nd request.
        run_walk(3, 2, 64'h2000, 1);
        // start held high through the whole walk with different cfg: ignored.
        run_walk(3, 2, 64'h3000, 3);
        run_walk(4, 0, 64'h4000, 0);

        // Zero rows: busy and done together the cycle after start, no request.
        cfg_rows = 5'd0; cfg_cols = 5'd5; cfg_base = 64'h5000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_busy", busy, 1'b1);
        chk("zero_done", done, 1'b1);
        chk("zero_req_valid", req_valid, 1'b0);
        tick();
        chk("zero_idle_busy", busy, 1'b0);
        chk("zero_idle_done", done, 1'b0);

        for (int w = 0; w < 12; w++) begin
            run_walk(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                     {$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        // Stray response while idle.
        chk("err_before", err_unexp, 1'b0);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        chk("err_idle_rsp", err_unexp, 1'b1);
        tick();
        chk("err_sticky", err_unexp, 1'b1);

        // Outstanding limit with no responses, then a simultaneous accept+response.
        cfg_rows = 5'd16; cfg_cols = 5'd1; cfg_base = 64'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        req_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            if (req_valid) acc++;
            tick();
        end
        chk("ost_accepts", acc, 8);
        chk("ost_full_valid", req_valid, 1'b0);
        rsp_valid = 1'b1;
        tick();
        chk("ost_after_rsp_valid", req_valid, 1'b1);
        tick();
        rsp_valid = 1'b0;
        chk("ost_simul_valid", req_valid, 1'b1);
        chk("ost_simul_row", req_row, 9);
        tick();
        req_ready = 1'b0;
        chk("ost_refull_valid", req_valid, 1'b0);
        chk("ost_refull_row", req_row, 10);

        // Asynchronous reset mid-walk with 8 reads still in flight.
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_done", done, 1'b0);
        chk("rmid_req_valid", req_valid, 1'b0);
        chk("rmid_req_last", req_last, 1'b0);
        chk("rmid_req_addr", req_addr, 64'h0);
        chk("rmid_req_row", req_row, 0);
        chk("rmid_req_col", req_col, 0);
        chk("rmid_err_unexp", err_unexp, 1'b0);
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        rsp_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
            rsp_valid = 1'b0;
        end
        chk("rmid_no_done", saw_done, 1'b0);
        chk("rmid_late_rsp_err", err_unexp, 1'b1);

        // Address wrap on the 8-bit instance.
        cfg_rows8 = 5'd2; cfg_cols8 = 5'd1; cfg_base8 = 8'hFC;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        req_ready8 = 1'b1;
        chk("wrap0_valid", req_valid8, 1'b1);
        chk("wrap0_addr", req_addr8, 8'hFC);
        chk("wrap0_last", req_last8, 1'b0);
        $display("wrap req 1 row=%0d addr=0x%0h", req_row8, req_addr8);
        tick();
        chk("wrap1_valid", req_valid8, 1'b1);
        chk("wrap1_addr", req_addr8, 8'h00);
        chk("wrap1_row", req_row8, 1);
        chk("wrap1_last", req_last8, 1'b1);
        $display("wrap req 2 row=%0d addr=0x%0h", req_row8, req_addr8);
        tick();
        req_ready8 = 1'b0;
        chk("wrap_drain_valid", req_valid8, 1'b0);
        rsp_valid8 = 1'b1;
        tick();
        tick();
        rsp_valid8 = 1'b0;
        chk("wrap_done", done8, 1'b1);
        chk("wrap_err", err_unexp8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
